// File: rtl/mem_pkg.sv
// Shared types for the memory stage: access sizes, trap codes and FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_MISALIGN = 2'd1,
        TRAP_BUSERR   = 2'd2
    } trap_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Purely combinational data-path helper for the memory stage: alignment check,
// byte-lane enables, store-data replication and load extraction/extension.
module lsu_align
    import mem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  size_e             size_i,
    input  logic              rdu_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic              misaligned_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   load_o
);

    logic [XLEN/8-1:0] lane_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   bit_mask;
    logic              sign_bit;

    // Per-size alignment, lane mask, store replication and load sign bit.
    always_comb begin
        misaligned_o = 1'b0;
        lane_mask    = '1;
        wdata_o      = wdata_i;
        bit_mask     = '1;
        sign_bit     = 1'b0;
        shifted      = rdata_i >> {offset_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                lane_mask = (XLEN/8)'(1'b1);
                wdata_o   = {(XLEN/8){wdata_i[7:0]}};
                bit_mask  = XLEN'(8'hFF);
                sign_bit  = shifted[7];
            end
            SZ_HALF: begin
                misaligned_o = offset_i[0];
                lane_mask    = (XLEN/8)'(2'b11);
                wdata_o      = {(XLEN/16){wdata_i[15:0]}};
                bit_mask     = XLEN'(16'hFFFF);
                sign_bit     = shifted[15];
            end
            SZ_WORD: begin
                misaligned_o = |offset_i[1:0];
                lane_mask    = (XLEN/8)'(4'hF);
                wdata_o      = {(XLEN/32){wdata_i[31:0]}};
                bit_mask     = XLEN'(32'hFFFF_FFFF);
                sign_bit     = shifted[31];
            end
            SZ_DWORD: begin
                // A doubleword cannot be expressed on a 32-bit bus at all.
                misaligned_o = (XLEN == 32) ? 1'b1 : (|offset_i);
            end
        endcase
    end

    // Full-width accesses have an all-ones mask, so extension is a no-op there.
    always_comb begin
        be_o   = lane_mask << offset_i;
        load_o = (shifted & bit_mask) | ((sign_bit & ~rdu_i) ? ~bit_mask : '0);
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: issues one data-memory transaction at a time, stalls upstream
// while it is outstanding, and registers the writeback payload.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no transaction outstanding; memory ops request this cycle
//   ST_WAIT | request outstanding, waiting for ack or timeout
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RD_W    = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_exec_mem_valid,
    input  logic [RD_W-1:0]   i_exec_mem_rd,
    input  logic              i_exec_mem_writeback,
    input  logic              i_exec_mem_link,
    input  logic [XLEN-1:0]   i_exec_mem_link_addr,
    input  logic              i_exec_mem_mem_r,
    input  logic              i_exec_mem_mem_w,
    input  logic              i_exec_mem_mem_rdu,
    input  logic [1:0]        i_exec_mem_mem_size,
    input  logic [XLEN-1:0]   i_exec_mem_alu_result,
    input  logic [XLEN-1:0]   i_exec_mem_mem_wdata,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic [XLEN/8-1:0] o_dmem_be,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_ack,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic              o_mem_stall,
    output logic              o_mem_wb_valid,
    output logic              o_mem_wb_writeback,
    output logic [RD_W-1:0]   o_mem_wb_rd,
    output logic [XLEN-1:0]   o_mem_wb_data,
    output logic [1:0]        o_mem_wb_trap
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               wb_valid_q, wb_valid_d;
    logic               wb_writeback_q, wb_writeback_d;
    logic [RD_W-1:0]    wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    trap_e              wb_trap_q, wb_trap_d;

    logic               is_mem;
    logic               misaligned;
    logic [BE_W-1:0]    be;
    logic [XLEN-1:0]    wdata_rep;
    logic [XLEN-1:0]    load_data;
    logic               req;
    logic               stall;
    logic               done;
    logic               req_out;

    assign is_mem = i_exec_mem_valid & (i_exec_mem_mem_r | i_exec_mem_mem_w);

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size_i       (size_e'(i_exec_mem_mem_size)),
        .rdu_i        (i_exec_mem_mem_rdu),
        .offset_i     (i_exec_mem_alu_result[OFF_W-1:0]),
        .wdata_i      (i_exec_mem_mem_wdata),
        .rdata_i      (i_dmem_rdata),
        .misaligned_o (misaligned),
        .be_o         (be),
        .wdata_o      (wdata_rep),
        .load_o       (load_data)
    );

    // Next-state, request/stall and writeback payload selection.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req            = 1'b0;
        stall          = 1'b0;
        done           = 1'b0;
        wb_valid_d     = 1'b0;
        wb_writeback_d = 1'b0;
        wb_rd_d        = '0;
        wb_data_d      = '0;
        wb_trap_d      = TRAP_NONE;
        case (state_q)
            ST_IDLE: begin
                if (!is_mem) begin
                    wb_valid_d     = i_exec_mem_valid;
                    wb_writeback_d = i_exec_mem_writeback;
                    wb_rd_d        = i_exec_mem_rd;
                    wb_data_d      = i_exec_mem_link ? i_exec_mem_link_addr
                                                     : i_exec_mem_alu_result;
                end else if (misaligned) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = i_exec_mem_rd;
                    wb_data_d  = i_exec_mem_alu_result;
                    wb_trap_d  = TRAP_MISALIGN;
                end else begin
                    req = 1'b1;
                    if (i_dmem_ack) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (i_dmem_ack) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
                    req        = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = i_exec_mem_rd;
                    wb_data_d  = i_exec_mem_alu_result;
                    wb_trap_d  = TRAP_BUSERR;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Stores complete with writeback suppressed; loads honour the rd enable.
        if (done) begin
            wb_valid_d     = 1'b1;
            wb_writeback_d = i_exec_mem_mem_r & ~i_exec_mem_mem_w & i_exec_mem_writeback;
            wb_rd_d        = i_exec_mem_rd;
            wb_data_d      = load_data;
        end
    end

    // FSM state and timeout counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writeback payload register toward the writeback stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wb_valid_q     <= 1'b0;
            wb_writeback_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_trap_q      <= TRAP_NONE;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_writeback_q <= wb_writeback_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_trap_q      <= wb_trap_d;
        end
    end

    // The idle state can request combinationally from live inputs, so reset
    // also masks the bus and stall outputs directly.
    assign req_out      = req & ~i_rst;
    assign o_dmem_req   = req_out;
    assign o_dmem_we    = req_out & i_exec_mem_mem_w;
    assign o_dmem_addr  = req_out ? {i_exec_mem_alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign o_dmem_be    = req_out ? be : '0;
    assign o_dmem_wdata = req_out ? wdata_rep : '0;
    assign o_mem_stall  = stall & ~i_rst;

    assign o_mem_wb_valid     = wb_valid_q;
    assign o_mem_wb_writeback = wb_writeback_q;
    assign o_mem_wb_rd        = wb_rd_q;
    assign o_mem_wb_data      = wb_data_q;
    assign o_mem_wb_trap      = wb_trap_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed, table-driven bench for mem_stage_lsu (XLEN=32, TIMEOUT=16).
module tb_mem_stage_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_exec_mem_valid;
    logic [5:0]  i_exec_mem_rd;
    logic        i_exec_mem_writeback;
    logic        i_exec_mem_link;
    logic [31:0] i_exec_mem_link_addr;
    logic        i_exec_mem_mem_r;
    logic        i_exec_mem_mem_w;
    logic        i_exec_mem_mem_rdu;
    logic [1:0]  i_exec_mem_mem_size;
    logic [31:0] i_exec_mem_alu_result;
    logic [31:0] i_exec_mem_mem_wdata;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_mem_stall;
    logic        o_mem_wb_valid;
    logic        o_mem_wb_writeback;
    logic [5:0]  o_mem_wb_rd;
    logic [31:0] o_mem_wb_data;
    logic [1:0]  o_mem_wb_trap;

    int checks   = 0;
    int failures = 0;

    mem_stage_lsu #(.XLEN(32), .RD_W(6), .TIMEOUT(16)) dut (
        .i_clk                 (i_clk),
        .i_rst                 (i_rst),
        .i_exec_mem_valid      (i_exec_mem_valid),
        .i_exec_mem_rd         (i_exec_mem_rd),
        .i_exec_mem_writeback  (i_exec_mem_writeback),
        .i_exec_mem_link       (i_exec_mem_link),
        .i_exec_mem_link_addr  (i_exec_mem_link_addr),
        .i_exec_mem_mem_r      (i_exec_mem_mem_r),
        .i_exec_mem_mem_w      (i_exec_mem_mem_w),
        .i_exec_mem_mem_rdu    (i_exec_mem_mem_rdu),
        .i_exec_mem_mem_size   (i_exec_mem_mem_size),
        .i_exec_mem_alu_result (i_exec_mem_alu_result),
        .i_exec_mem_mem_wdata  (i_exec_mem_mem_wdata),
        .o_dmem_req            (o_dmem_req),
        .o_dmem_we             (o_dmem_we),
        .o_dmem_addr           (o_dmem_addr),
        .o_dmem_be             (o_dmem_be),
        .o_dmem_wdata          (o_dmem_wdata),
        .i_dmem_ack            (i_dmem_ack),
        .i_dmem_rdata          (i_dmem_rdata),
        .o_mem_stall           (o_mem_stall),
        .o_mem_wb_valid        (o_mem_wb_valid),
        .o_mem_wb_writeback    (o_mem_wb_writeback),
        .o_mem_wb_rd           (o_mem_wb_rd),
        .o_mem_wb_data         (o_mem_wb_data),
        .o_mem_wb_trap         (o_mem_wb_trap)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        valid;
        logic [5:0]  rd;
        logic        wb;
        logic        link;
        logic [31:0] link_addr;
        logic        r;
        logic        w;
        logic        rdu;
        logic [1:0]  size;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_vld;
        logic        e_wbw;
        logic [1:0]  e_trap;
        logic [31:0] e_data;
        logic        chk;
    } vec_t;

    localparam int NV = 13;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        i_exec_mem_valid      = 1'b0;
        i_exec_mem_rd         = '0;
        i_exec_mem_writeback  = 1'b0;
        i_exec_mem_link       = 1'b0;
        i_exec_mem_link_addr  = '0;
        i_exec_mem_mem_r      = 1'b0;
        i_exec_mem_mem_w      = 1'b0;
        i_exec_mem_mem_rdu    = 1'b0;
        i_exec_mem_mem_size   = 2'd0;
        i_exec_mem_alu_result = '0;
        i_exec_mem_mem_wdata  = '0;
        i_dmem_ack            = 1'b0;
        i_dmem_rdata          = '0;
    endtask

    task automatic drive(input vec_t v);
        i_exec_mem_valid      = v.valid;
        i_exec_mem_rd         = v.rd;
        i_exec_mem_writeback  = v.wb;
        i_exec_mem_link       = v.link;
        i_exec_mem_link_addr  = v.link_addr;
        i_exec_mem_mem_r      = v.r;
        i_exec_mem_mem_w      = v.w;
        i_exec_mem_mem_rdu    = v.rdu;
        i_exec_mem_mem_size   = v.size;
        i_exec_mem_alu_result = v.alu;
        i_exec_mem_mem_wdata  = v.wdata;
        i_dmem_ack            = v.ack;
        i_dmem_rdata          = v.rdata;
    endtask

    // Byte load at 0x1003 acknowledged after three stalled cycles.
    task automatic wait_load(input logic rdu, input logic [31:0] exp, input string nm);
        clr();
        i_exec_mem_valid      = 1'b1;
        i_exec_mem_rd         = 6'd6;
        i_exec_mem_writeback  = 1'b1;
        i_exec_mem_mem_r      = 1'b1;
        i_exec_mem_mem_rdu    = rdu;
        i_exec_mem_mem_size   = 2'd0;
        i_exec_mem_alu_result = 32'h1003;
        i_dmem_rdata          = 32'h80FF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk({nm, "_req"},   o_dmem_req,  1);
            chk({nm, "_stall"}, o_mem_stall, 1);
            chk({nm, "_be"},    o_dmem_be,   4'b1000);
            chk({nm, "_addr"},  o_dmem_addr, 32'h1000);
            @(posedge i_clk); #1;
            chk({nm, "_bubble"}, o_mem_wb_valid, 0);
        end
        i_dmem_ack = 1'b1;
        @(negedge i_clk);
        chk({nm, "_ack_stall"}, o_mem_stall, 0);
        chk({nm, "_ack_req"},   o_dmem_req,  1);
        @(posedge i_clk); #1;
        chk({nm, "_vld"},  o_mem_wb_valid,     1);
        chk({nm, "_wbw"},  o_mem_wb_writeback, 1);
        chk({nm, "_rd"},   o_mem_wb_rd,        6'd6);
        chk({nm, "_data"}, o_mem_wb_data,      exp);
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nstall;
        logic done;

        // valid rd wb link link_addr r w rdu size alu wdata ack rdata | req we be addr wdata | vld wbw trap data chk
        tv[0]  = '{1'b1,6'd5,1'b1,1'b0,32'h0,  1'b0,1'b0,1'b0,2'd0,32'h1234,32'h0,   1'b1,32'h0,        1'b0,1'b0,4'h0,32'h0,   32'h0,        1'b1,1'b1,2'd0,32'h1234,    1'b1};
        tv[1]  = '{1'b1,6'd1,1'b1,1'b1,32'h104,1'b0,1'b0,1'b0,2'd2,32'h999, 32'h0,   1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,   32'h0,        1'b1,1'b1,2'd0,32'h104,     1'b1};
        tv[2]  = '{1'b1,6'd0,1'b0,1'b0,32'h0,  1'b0,1'b1,1'b0,2'd1,32'h2002,32'hBEEF,1'b1,32'h0,        1'b1,1'b1,4'hC,32'h2000,32'hBEEFBEEF, 1'b1,1'b0,2'd0,32'h0,       1'b1};
        tv[3]  = '{1'b1,6'd7,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,2'd2,32'h2001,32'h0,   1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,   32'h0,        1'b1,1'b0,2'd1,32'h2001,    1'b1};
        tv[4]  = '{1'b1,6'd3,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,2'd0,32'h1003,32'h0,   1'b1,32'h80FFFFFF, 1'b1,1'b0,4'h8,32'h1000,32'h0,        1'b1,1'b1,2'd0,32'hFFFFFF80,1'b1};
        tv[5]  = '{1'b1,6'd4,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b1,2'd1,32'h1002,32'h0,   1'b1,32'h80011234, 1'b1,1'b0,4'hC,32'h1000,32'h0,        1'b1,1'b1,2'd0,32'h00008001,1'b1};
        tv[6]  = '{1'b1,6'd4,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,2'd1,32'h1000,32'h0,   1'b1,32'h1234F00D, 1'b1,1'b0,4'h3,32'h1000,32'h0,        1'b1,1'b1,2'd0,32'hFFFFF00D,1'b1};
        tv[7]  = '{1'b1,6'd9,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,2'd2,32'h3000,32'h0,   1'b1,32'hDEADBEEF, 1'b1,1'b0,4'hF,32'h3000,32'h0,        1'b1,1'b1,2'd0,32'hDEADBEEF,1'b1};
        tv[8]  = '{1'b1,6'd0,1'b0,1'b0,32'h0,  1'b0,1'b1,1'b0,2'd0,32'h11,  32'hA5,  1'b1,32'h0,        1'b1,1'b1,4'h2,32'h10,  32'hA5A5A5A5, 1'b1,1'b0,2'd0,32'h0,       1'b1};
        tv[9]  = '{1'b1,6'd2,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,2'd3,32'h4000,32'h0,   1'b1,32'h0,        1'b0,1'b0,4'h0,32'h0,   32'h0,        1'b1,1'b0,2'd1,32'h4000,    1'b1};
        tv[10] = '{1'b1,6'd2,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b0,2'd1,32'h1001,32'h0,   1'b0,32'h0,        1'b0,1'b0,4'h0,32'h0,   32'h0,        1'b1,1'b0,2'd1,32'h1001,    1'b1};
        tv[11] = '{1'b0,6'd0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,2'd2,32'h3000,32'h0,   1'b1,32'h0,        1'b0,1'b0,4'h0,32'h0,   32'h0,        1'b0,1'b0,2'd0,32'h0,       1'b0};
        tv[12] = '{1'b1,6'd8,1'b1,1'b0,32'h0,  1'b1,1'b0,1'b1,2'd0,32'h1001,32'h0,   1'b1,32'h0000FE00, 1'b1,1'b0,4'h2,32'h1000,32'h0,        1'b1,1'b1,2'd0,32'h000000FE,1'b1};

        // Reset with an aligned load presented: every output must stay 0.
        clr();
        i_rst                 = 1'b1;
        i_exec_mem_valid      = 1'b1;
        i_exec_mem_mem_r      = 1'b1;
        i_exec_mem_mem_size   = 2'd2;
        i_exec_mem_alu_result = 32'h1000;
        i_exec_mem_mem_wdata  = 32'h5555_5555;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req",   o_dmem_req,     0);
        chk("rst_we",    o_dmem_we,      0);
        chk("rst_addr",  o_dmem_addr,    0);
        chk("rst_be",    o_dmem_be,      0);
        chk("rst_wdata", o_dmem_wdata,   0);
        chk("rst_stall", o_mem_stall,    0);
        chk("rst_vld",   o_mem_wb_valid, 0);
        chk("rst_wbw",   o_mem_wb_writeback, 0);
        chk("rst_rd",    o_mem_wb_rd,    0);
        chk("rst_data",  o_mem_wb_data,  0);
        chk("rst_trap",  o_mem_wb_trap,  0);
        clr();
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Single-cycle operations from the table.
        for (int k = 0; k < NV; k++) begin
            drive(tv[k]);
            @(negedge i_clk);
            chk($sformatf("v%0d_req", k),   o_dmem_req,   tv[k].e_req);
            chk($sformatf("v%0d_we", k),    o_dmem_we,    tv[k].e_we);
            chk($sformatf("v%0d_be", k),    o_dmem_be,    tv[k].e_be);
            chk($sformatf("v%0d_addr", k),  o_dmem_addr,  tv[k].e_addr);
            chk($sformatf("v%0d_wdata", k), o_dmem_wdata, tv[k].e_wdata);
            chk($sformatf("v%0d_stall", k), o_mem_stall,  0);
            @(posedge i_clk); #1;
            chk($sformatf("v%0d_vld", k), o_mem_wb_valid, tv[k].e_vld);
            if (tv[k].chk) begin
                chk($sformatf("v%0d_wbw", k),  o_mem_wb_writeback, tv[k].e_wbw);
                chk($sformatf("v%0d_rd", k),   o_mem_wb_rd,        tv[k].rd);
                chk($sformatf("v%0d_trap", k), o_mem_wb_trap,      tv[k].e_trap);
                chk($sformatf("v%0d_data", k), o_mem_wb_data,      tv[k].e_data);
            end
        end
        clr();

        // Multi-cycle loads, signed then zero-extended.
        wait_load(1'b0, 32'hFFFF_FF80, "wait_sext");
        wait_load(1'b1, 32'h0000_0080, "wait_zext");

        // Bus timeout: stall lasts exactly TIMEOUT-1 cycles.
        i_exec_mem_valid      = 1'b1;
        i_exec_mem_rd         = 6'd11;
        i_exec_mem_writeback  = 1'b1;
        i_exec_mem_mem_r      = 1'b1;
        i_exec_mem_mem_size   = 2'd2;
        i_exec_mem_alu_result = 32'h5000;
        nstall = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge i_clk);
            if (o_mem_stall) begin
                nstall++;
                @(posedge i_clk); #1;
            end else begin
                done = 1'b1;
                chk("to_req_drop", o_dmem_req, 0);
            end
        end
        chk("to_completed", done, 1);
        chk("to_stall_cycles", nstall, 15);
        @(posedge i_clk); #1;
        chk("to_vld",  o_mem_wb_valid,     1);
        chk("to_wbw",  o_mem_wb_writeback, 0);
        chk("to_trap", o_mem_wb_trap,      2);
        chk("to_data", o_mem_wb_data,      32'h5000);
        chk("to_rd",   o_mem_wb_rd,        6'd11);
        clr();
        i_dmem_ack = 1'b1;
        @(negedge i_clk);
        chk("late_ack_req", o_dmem_req, 0);
        @(posedge i_clk); #1;
        chk("late_ack_vld", o_mem_wb_valid, 0);
        i_dmem_ack = 1'b0;

        // Reset in the middle of a wait.
        i_exec_mem_valid      = 1'b1;
        i_exec_mem_rd         = 6'd12;
        i_exec_mem_writeback  = 1'b1;
        i_exec_mem_mem_r      = 1'b1;
        i_exec_mem_mem_size   = 2'd2;
        i_exec_mem_alu_result = 32'h6000;
        repeat (2) begin
            @(posedge i_clk); #1;
        end
        @(negedge i_clk);
        chk("mid_wait_stall", o_mem_stall, 1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_req",   o_dmem_req,     0);
        chk("mid_rst_stall", o_mem_stall,    0);
        chk("mid_rst_vld",   o_mem_wb_valid, 0);
        clr();
        @(posedge i_clk); #1;
        i_rst      = 1'b0;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'h1234_5678;
        @(negedge i_clk);
        chk("post_rst_req", o_dmem_req, 0);
        @(posedge i_clk); #1;
        chk("post_rst_vld", o_mem_wb_valid, 0);
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
